// File: rtl/vliw_pkg.sv
// Shared definitions for the two-slot VLIW front end: bundle layout,
// redirect-select encodings, fetch FSM encodings and the sequential PC step.
package vliw_pkg;

  localparam int BUNDLE_W     = 64;
  localparam int OPCODE_W     = 10;
  localparam int SLOT0_OP_LSB = 32;
  localparam int SLOT0_OP_MSB = 41;
  localparam int SLOT1_OP_LSB = 0;
  localparam int SLOT1_OP_MSB = 9;

  typedef logic [1:0] pc_sel_t;
  localparam pc_sel_t PCSEL_SEQ = 2'b00;
  localparam pc_sel_t PCSEL_BR  = 2'b01;
  localparam pc_sel_t PCSEL_JMP = 2'b10;
  localparam pc_sel_t PCSEL_EXC = 2'b11;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE   = 2'd0;
  localparam fetch_state_t ST_WAIT   = 2'd1;
  localparam fetch_state_t ST_SQUASH = 2'd2;

  localparam logic [31:0] PC_INC = 32'd8;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_pending_buf.sv
// One-entry holding register for a bundle (and its PC) that returned from
// memory while decode was stalled. Clear wins over load, load wins over drain.
module fetch_pending_buf
  import vliw_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [BUNDLE_W-1:0] load_bundle,
  input  logic [31:0]         load_pc,
  input  logic                drain,
  input  logic                clear,
  output logic                full,
  output logic [BUNDLE_W-1:0] bundle,
  output logic [31:0]         pc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full   <= 1'b0;
      bundle <= '0;
      pc     <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full   <= 1'b1;
      bundle <= load_bundle;
      pc     <= load_pc;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/vliw_fetch_unit.sv
// Instruction fetch and IF/ID register of the two-slot VLIW core.
// Optional build macro FETCH_STATS_EN adds saturating bundle/flush counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no request outstanding; request pc when pending buffer empty
// ST_WAIT   | one request outstanding; its response is delivered
// ST_SQUASH | one request outstanding; its response is discarded
module vliw_fetch_unit
  import vliw_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          pc_in,
  input  logic                IF_Flush,
  input  logic [31:0]         branch_target,
  input  logic [31:0]         jump_target,
  input  logic                id_stall,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ready,
  input  logic                imem_valid,
  input  logic [BUNDLE_W-1:0] imem_rdata,
  output logic                if_id_valid,
  output logic [BUNDLE_W-1:0] if_id_bundle,
  output logic [31:0]         if_id_pc,
  output logic [OPCODE_W-1:0] opcode_memtype,
  output logic [OPCODE_W-1:0] opcode_rtype,
  output logic [31:0]         epc_value
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         stat_bundles,
  output logic [31:0]         stat_flushes
`endif
);

  fetch_state_t        state_q, state_d;
  logic [31:0]         pc_q, fetch_pc_q, redir_target;
  logic                pb_full, pb_load;
  logic [BUNDLE_W-1:0] pb_bundle;
  logic [31:0]         pb_pc;
  logic                hs, rsp, redir_acc, flush_bubble, bubble;
  logic                deliver_pb, deliver_rsp;

  // Gated by reset_n so no request leaks out while reset is held.
  assign imem_req  = reset_n && (state_q == ST_IDLE) && !pb_full;
  assign imem_addr = pc_q;
  assign hs        = imem_req && imem_ready;
  assign rsp       = imem_valid && (state_q == ST_WAIT);

  // An exception redirect cannot be held off by a decode stall.
  assign redir_acc    = (pc_in != PCSEL_SEQ) && (!id_stall || (pc_in == PCSEL_EXC));
  assign flush_bubble = IF_Flush && (pc_in == PCSEL_SEQ) && !id_stall;
  assign bubble       = redir_acc || flush_bubble;

  assign deliver_pb  = !bubble && !id_stall && pb_full;
  assign deliver_rsp = !bubble && !id_stall && rsp;
  assign pb_load     = rsp && id_stall && !redir_acc;

  always_comb begin
    redir_target = pc_q;
    case (pc_in)
      PCSEL_BR:  redir_target = branch_target;
      PCSEL_JMP: redir_target = jump_target;
      PCSEL_EXC: redir_target = EXC_VECTOR;
      default:   redir_target = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (hs) state_d = redir_acc ? ST_SQUASH : ST_WAIT;
      ST_WAIT: begin
        if (imem_valid)     state_d = ST_IDLE;
        else if (redir_acc) state_d = ST_SQUASH;
      end
      ST_SQUASH: if (imem_valid) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (redir_acc)  pc_q <= redir_target;
      else if (hs)    pc_q <= next_seq_pc(pc_q);
      if (hs) fetch_pc_q <= pc_q;
    end
  end

  fetch_pending_buf u_pending_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (pb_load),
    .load_bundle (imem_rdata),
    .load_pc     (fetch_pc_q),
    .drain       (deliver_pb),
    .clear       (bubble),
    .full        (pb_full),
    .bundle      (pb_bundle),
    .pc          (pb_pc)
  );

  // With nothing to hand over, an unstalled IF/ID falls to a bubble so decode
  // never sees the same bundle twice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_id_valid  <= 1'b0;
      if_id_bundle <= '0;
      if_id_pc     <= '0;
    end else if (bubble || (!id_stall && !deliver_pb && !deliver_rsp)) begin
      if_id_valid  <= 1'b0;
      if_id_bundle <= '0;
      if_id_pc     <= '0;
    end else if (deliver_pb) begin
      if_id_valid  <= 1'b1;
      if_id_bundle <= pb_bundle;
      if_id_pc     <= pb_pc;
    end else if (deliver_rsp) begin
      if_id_valid  <= 1'b1;
      if_id_bundle <= imem_rdata;
      if_id_pc     <= fetch_pc_q;
    end
  end

  assign opcode_memtype = if_id_bundle[SLOT0_OP_MSB:SLOT0_OP_LSB];
  assign opcode_rtype   = if_id_bundle[SLOT1_OP_MSB:SLOT1_OP_LSB];
  assign epc_value      = if_id_pc;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_bundles <= '0;
      stat_flushes <= '0;
    end else begin
      if ((deliver_pb || deliver_rsp) && (stat_bundles != 32'hFFFF_FFFF))
        stat_bundles <= stat_bundles + 32'd1;
      if (bubble && (stat_flushes != 32'hFFFF_FFFF))
        stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

  // A response with nothing outstanding means the memory broke protocol.
  idle_no_response: assert property (@(posedge clk) disable iff (!reset_n)
    !(imem_valid && (state_q == ST_IDLE)));

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Directed self-checking bench for vliw_fetch_unit (stats checks under FETCH_STATS_EN).
module tb_vliw_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  pc_in;
  logic        IF_Flush;
  logic [31:0] branch_target, jump_target;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_valid;
  logic [63:0] imem_rdata;
  logic        if_id_valid;
  logic [63:0] if_id_bundle;
  logic [31:0] if_id_pc;
  logic [9:0]  opcode_memtype, opcode_rtype;
  logic [31:0] epc_value;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_bundles, stat_flushes;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vliw_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_in          (pc_in),
    .IF_Flush       (IF_Flush),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .id_stall       (id_stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_bundle   (if_id_bundle),
    .if_id_pc       (if_id_pc),
    .opcode_memtype (opcode_memtype),
    .opcode_rtype   (opcode_rtype),
    .epc_value      (epc_value)
`ifdef FETCH_STATS_EN
    ,
    .stat_bundles   (stat_bundles),
    .stat_flushes   (stat_flushes)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered at a negedge with the unit idle; one request, one zero-wait response.
  task automatic do_fetch(input logic [31:0] addr, input logic [63:0] data);
    chk("fetch_req", {63'd0, imem_req}, 64'd1);
    chk("fetch_addr", {32'd0, imem_addr}, {32'd0, addr});
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("wait_no_req", {63'd0, imem_req}, 64'd0);
    imem_valid = 1'b1;
    imem_rdata = data;
    tick();
    imem_valid = 1'b0;
    chk("ifid_valid", {63'd0, if_id_valid}, 64'd1);
    chk("ifid_pc", {32'd0, if_id_pc}, {32'd0, addr});
    chk("ifid_bundle", if_id_bundle, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n = 1'b0; pc_in = 2'b00; IF_Flush = 1'b0;
    branch_target = '0; jump_target = '0; id_stall = 1'b0;
    imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    repeat (3) tick();

    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_addr", {32'd0, imem_addr}, 64'd0);
    chk("rst_valid", {63'd0, if_id_valid}, 64'd0);
    chk("rst_bundle", if_id_bundle, 64'd0);
    chk("rst_pc", {32'd0, if_id_pc}, 64'd0);

    reset_n = 1'b1;
    tick();

    // Sequential fetch from reset
    do_fetch(32'h0, 64'h1111_2222_3333_0155);
    chk("op_rtype", {54'd0, opcode_rtype}, 64'h155);
    chk("op_memtype", {54'd0, opcode_memtype}, 64'h222);
    do_fetch(32'h8, 64'hAAAA_0001_BBBB_0002);
    do_fetch(32'h10, 64'h0123_4567_89AB_CDEF);
    chk("op_rtype2", {54'd0, opcode_rtype}, 64'h1EF);

    // Jump while waiting on a late response
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    pc_in = 2'b10; jump_target = 32'h200;
    tick();
    pc_in = 2'b00;
    chk("jmp_bubble_valid", {63'd0, if_id_valid}, 64'd0);
    chk("jmp_bubble_bundle", if_id_bundle, 64'd0);
    chk("jmp_squash_no_req", {63'd0, imem_req}, 64'd0);
    tick();
    imem_valid = 1'b1; imem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    imem_valid = 1'b0;
    chk("stale_dropped", {63'd0, if_id_valid}, 64'd0);
    do_fetch(32'h200, 64'h0000_0300_0000_0301);

    // Response returns under a 4-cycle stall
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    id_stall = 1'b1;
    imem_valid = 1'b1; imem_rdata = 64'h4444_0044_5555_0055;
    tick();
    imem_valid = 1'b0;
    chk("stall_no_req", {63'd0, imem_req}, 64'd0);
    chk("stall_held", {63'd0, if_id_valid}, 64'd0);
    repeat (3) tick();
    chk("stall_no_req4", {63'd0, imem_req}, 64'd0);
    id_stall = 1'b0;
    tick();
    chk("drain_valid", {63'd0, if_id_valid}, 64'd1);
    chk("drain_pc", {32'd0, if_id_pc}, 64'h208);
    chk("drain_bundle", if_id_bundle, 64'h4444_0044_5555_0055);
    chk("drain_next_addr", {32'd0, imem_addr}, 64'h210);

    // Exception while stalled with a full pending buffer
    do_fetch(32'h210, 64'h6666_0066_7777_0077);
    id_stall = 1'b1; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    imem_valid = 1'b1; imem_rdata = 64'h8888_0088_9999_0099;
    tick();
    imem_valid = 1'b0;
    chk("exc_buf_full_no_req", {63'd0, imem_req}, 64'd0);
    pc_in = 2'b11;
    #1;
    chk("exc_epc", {32'd0, epc_value}, 64'h210);
    tick();
    pc_in = 2'b00;
    chk("exc_req", {63'd0, imem_req}, 64'd1);
    chk("exc_addr", {32'd0, imem_addr}, 64'h80);
    chk("exc_bubble", {63'd0, if_id_valid}, 64'd0);
    id_stall = 1'b0;
    tick();
    chk("exc_buf_cleared", {63'd0, if_id_valid}, 64'd0);
    do_fetch(32'h80, 64'h0000_0011_0000_0022);

    // IF_Flush bubble leaves the PC alone
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    imem_valid = 1'b1; imem_rdata = 64'hFFFF_0000_FFFF_0000; IF_Flush = 1'b1;
    tick();
    imem_valid = 1'b0; IF_Flush = 1'b0;
    chk("flush_bubble", {63'd0, if_id_valid}, 64'd0);
    chk("flush_pc_kept", {32'd0, imem_addr}, 64'h90);

    // Branch coinciding with a handshake squashes that request
    imem_ready = 1'b1; pc_in = 2'b01; branch_target = 32'h400;
    tick();
    imem_ready = 1'b0; pc_in = 2'b00;
    chk("br_squash_no_req", {63'd0, imem_req}, 64'd0);
    imem_valid = 1'b1; imem_rdata = 64'h1234_1234_1234_1234;
    tick();
    imem_valid = 1'b0;
    chk("br_addr", {32'd0, imem_addr}, 64'h400);
    chk("br_stale_dropped", {63'd0, if_id_valid}, 64'd0);

    // Branch under stall is not accepted
    id_stall = 1'b1; pc_in = 2'b01; branch_target = 32'h500;
    tick();
    id_stall = 1'b0; pc_in = 2'b00;
    chk("br_stalled_ignored", {32'd0, imem_addr}, 64'h400);
    do_fetch(32'h400, 64'h0BAD_0000_C0DE_0000);

    // Reset in WAIT, response arrives during reset
    id_stall = 1'b1; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("prerst_valid", {63'd0, if_id_valid}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_req", {63'd0, imem_req}, 64'd0);
    chk("midrst_addr", {32'd0, imem_addr}, 64'd0);
    chk("midrst_valid", {63'd0, if_id_valid}, 64'd0);
    chk("midrst_pc", {32'd0, if_id_pc}, 64'd0);
    imem_valid = 1'b1; imem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    tick();
    tick();
    imem_valid = 1'b0; id_stall = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("postrst_req", {63'd0, imem_req}, 64'd1);
    chk("postrst_addr", {32'd0, imem_addr}, 64'd0);
    chk("postrst_valid", {63'd0, if_id_valid}, 64'd0);

    // Ten bundles then two branches
    for (int i = 0; i < 10; i++)
      do_fetch(32'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i));
    pc_in = 2'b01; branch_target = 32'h600;
    tick();
    pc_in = 2'b00;
    chk("br1_addr", {32'd0, imem_addr}, 64'h600);
    pc_in = 2'b01; branch_target = 32'h700;
    tick();
    pc_in = 2'b00;
    chk("br2_addr", {32'd0, imem_addr}, 64'h700);
`ifdef FETCH_STATS_EN
    chk("stat_bundles", {32'd0, stat_bundles}, 64'd10);
    chk("stat_flushes", {32'd0, stat_flushes}, 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
